// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants and state type for the ALU control sequencer
package alu_ctrl_pkg;

  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_AND  = 4'd2;
  localparam logic [3:0] FUNC_OR   = 4'd3;
  localparam logic [3:0] FUNC_XOR  = 4'd4;
  localparam logic [3:0] FUNC_NOR  = 4'd5;
  localparam logic [3:0] FUNC_SLT  = 4'd6;
  localparam logic [3:0] FUNC_SLTU = 4'd7;
  localparam logic [3:0] FUNC_MUL  = 4'd8;
  localparam logic [3:0] FUNC_MULH = 4'd9;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  typedef enum logic {IDLE, EXEC} state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational decode of {alu_op, opcode} to func/multi/illegal
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int FUNC_W   = 4
) (
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func,
  output logic                multi,
  output logic                illegal
);

  always_comb begin
    func    = '0;
    multi   = 1'b0;
    illegal = 1'b0;
    // alu_op bits above the low two are reserved and must be zero
    if ((alu_op >> 2) != '0) begin
      illegal = 1'b1;
    end else begin
      case (alu_op[1:0])
        ALUOP_ADD: func = FUNC_W'(FUNC_ADD);
        ALUOP_SUB: func = FUNC_W'(FUNC_SUB);
        ALUOP_RTYPE: begin
          if (opcode >= OPCODE_W'(2) && opcode <= OPCODE_W'(9)) begin
            func = FUNC_W'(opcode[3:0] - 4'd2);
          end else if (opcode == OPCODE_W'(10)) begin
            func  = FUNC_W'(FUNC_MUL);
            multi = 1'b1;
          end else if (opcode == OPCODE_W'(11)) begin
            func  = FUNC_W'(FUNC_MULH);
            multi = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control with valid/ready front end and multi-cycle sequencer
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int ALUOP_W   = 2,
  parameter int FUNC_W    = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  output logic [FUNC_W-1:0]   alu_func,
  output logic                alu_start,
  output logic                busy,
  output logic                illegal
);

  localparam int CNT_W = $clog2(MC_CYCLES);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [FUNC_W-1:0]  func_d;
  logic               illegal_d, out_valid_d, alu_start_d;
  logic [FUNC_W-1:0]  dec_func;
  logic               dec_multi, dec_illegal;
  logic               accept;

  alu_ctrl_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W),
    .FUNC_W  (FUNC_W)
  ) u_decode (
    .alu_op (alu_op),
    .opcode (opcode),
    .func   (dec_func),
    .multi  (dec_multi),
    .illegal(dec_illegal)
  );

  // The final EXEC cycle (cnt==0) can already accept the next op
  assign in_ready = !rst && !flush && (state == IDLE || cnt == '0);
  assign busy     = (state == EXEC);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    func_d      = alu_func;
    illegal_d   = illegal;
    out_valid_d = 1'b0;
    alu_start_d = 1'b0;

    if (state == EXEC) begin
      if (cnt != '0) cnt_d = cnt - CNT_W'(1);
      // registered out_valid lands in the cnt==0 cycle
      if (cnt == CNT_W'(1)) out_valid_d = 1'b1;
      if (cnt == '0) state_d = IDLE;
    end

    if (accept) begin
      func_d    = dec_func;
      illegal_d = dec_illegal;
      if (dec_multi) begin
        state_d     = EXEC;
        cnt_d       = CNT_W'(MC_CYCLES - 1);
        alu_start_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
      end
    end

    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      alu_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_func  <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      alu_start <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      alu_func  <= func_d;
      illegal   <= illegal_d;
      out_valid <= out_valid_d;
      alu_start <= alu_start_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq with directed vectors
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid;
  logic       in_ready, out_valid, alu_start, busy, illegal;
  logic [1:0] alu_op;
  logic [3:0] opcode;
  logic [3:0] alu_func;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_e;

  alu_ctrl_seq #(
    .OPCODE_W (4),
    .ALUOP_W  (2),
    .FUNC_W   (4),
    .MC_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .opcode   (opcode),
    .out_valid(out_valid),
    .alu_func (alu_func),
    .alu_start(alu_start),
    .busy     (busy),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("sb_alu_func", alu_func, exp_e[3:0]);
        chk("sb_illegal", illegal, exp_e[4]);
      end
    end
  end

  // One cycle: check busy/alu_start for this cycle, drive inputs, check in_ready,
  // and push the expected result if the op should complete (e_func < 0: no push).
  task automatic cyc(input logic r, input logic v, input logic [1:0] op,
                     input logic [3:0] opc, input logic fl,
                     input int e_rdy, input int e_busy, input int e_start,
                     input int e_func, input int e_ill);
    @(posedge clk);
    #1;
    if (e_busy >= 0)  chk("busy", busy, e_busy);
    if (e_start >= 0) chk("alu_start", alu_start, e_start);
    rst = r; in_valid = v; alu_op = op; opcode = opc; flush = fl;
    #1;
    if (e_rdy >= 0) chk("in_ready", in_ready, e_rdy);
    if (v && e_rdy == 1 && e_func >= 0) exp_q.push_back({e_ill[0], e_func[3:0]});
  endtask

  logic [1:0] b_op  [8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  logic [3:0] b_opc [8] = '{4'd0,  4'd2,  4'd3,  4'd5,  4'd6,  4'd7,  4'd8,  4'd15};
  int         b_func[8] = '{1,     0,     1,     3,     4,     5,     6,     0};

  logic [1:0] i_op  [5] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
  logic [3:0] i_opc [5] = '{4'd6,  4'd0,  4'd1,  4'd12, 4'd10};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = 2'b00; opcode = 4'd0;
    cyc(1, 0, 2'b00, 4'd0, 0, -1, -1, -1, -1, 0);
    cyc(1, 1, 2'b10, 4'd0, 0, 0, -1, -1, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_illegal", illegal, 0);

    // basic decode
    cyc(0, 1, 2'b10, 4'd5, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 2'b00, 4'd4, 0, 1, 0, 0, 2, 0);
    cyc(0, 1, 2'b00, 4'd9, 0, 1, 0, 0, 7, 0);

    // back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) cyc(0, 1, b_op[i], b_opc[i], 0, 1, 0, 0, b_func[i], 0);

    // illegal encodings, single-cycle
    for (int i = 0; i < 5; i++) cyc(0, 1, i_op[i], i_opc[i], 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);

    // MUL then MULH accepted in MUL's final cycle
    cyc(0, 1, 2'b00, 4'd10, 0, 1, 0, 0, 8, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 1, -1, 0);
    cyc(0, 1, 2'b10, 4'd0, 0, 0, 1, 0, -1, 0);
    chk("func_hold", alu_func, 8);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 0, -1, 0);
    cyc(0, 1, 2'b00, 4'd11, 0, 1, 1, 0, 9, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 1, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 1, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);

    // flush in cycle 2 of a MUL with a concurrent input
    cyc(0, 1, 2'b00, 4'd10, 0, 1, 0, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 1, -1, 0);
    cyc(0, 1, 2'b10, 4'd0, 1, 0, 1, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);
    chk("flush_no_accept_func", alu_func, 8);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);

    // reset mid-EXEC, then a fresh op right after rst falls
    cyc(0, 1, 2'b00, 4'd10, 0, 1, 0, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 0, 1, 1, -1, 0);
    cyc(1, 0, 2'b00, 4'd0, 0, 0, 1, 0, -1, 0);
    cyc(0, 1, 2'b00, 4'd4, 0, 1, 0, 0, 2, 0);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_alu_func", alu_func, 0);
    chk("rstmid_illegal", illegal, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);
    cyc(0, 0, 2'b00, 4'd0, 0, 1, 0, 0, -1, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered ALU control unit with multi-cycle sequencing. It decodes `{alu_op, opcode}` into an ALU function code, like the existing combinational decode, and extends it with an illegal-encoding flag and a valid/ready input handshake. It also adds an iterative-op sequencer that holds the function stable and stalls the front end for `MC_CYCLES` cycles on multi-cycle functions (MUL/MULH). It sits between the main control unit and the ALU/multiplier datapath.

## Interface
- `OPCODE_W`, 4: opcode width; must be ≥4.
- `ALUOP_W`, 2: alu_op width; must be ≥2; only the low 2 bits are decoded, higher bits must be 0, else illegal.
- `FUNC_W`, 4: ALU function code width; must be ≥4.
- `MC_CYCLES`, 4: execution length of a multi-cycle function, in cycles; range 2..255.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous abort of any op in flight.
- `in_valid`  in  1: `alu_op`/`opcode` valid this cycle.
- `in_ready`  out  1: unit can accept this cycle.
- `alu_op`  in  `ALUOP_W`: class from main control.
- `opcode`  in  `OPCODE_W`: instruction function field.
- `out_valid`  out  1: `alu_func` result is complete this cycle (one-cycle pulse per accepted op).
- `alu_func`  out  `FUNC_W`: function code to the ALU; held stable while `busy`.
- `alu_start`  out  1: one-cycle pulse on the first execute cycle of a multi-cycle op.
- `busy`  out  1: multi-cycle op in progress.
- `illegal`  out  1: qualifies `out_valid`; the accepted encoding was undefined.

## Operation
- **Decode (zero-extended to `FUNC_W`):**
  - alu_op=10 → 0 (ADD), any opcode.
  - alu_op=01 → 1 (SUB), any opcode.
  - alu_op=00 with opcode 2..9 → opcode−2 (funcs 0..7).
  - alu_op=00 with opcode 10 → 8 (MUL, multi-cycle).
  - alu_op=00 with opcode 11 → 9 (MULH, multi-cycle).
  - Anything else (alu_op=11, opcode 0/1/≥12, nonzero high bits) → func 0 with `illegal`=1, treated as single-cycle.
- **Accept:** occurs when `in_valid && in_ready`.
- **States:** IDLE and EXEC.
  - IDLE: `in_ready` = !flush.
    - On accept of a single-cycle op, stay in IDLE and register func/illegal.
    - On accept of a multi-cycle op, go to EXEC, load counter = MC_CYCLES−1, and set `alu_start`.
  - EXEC: counter decrements each cycle; `alu_func` is held.
    - When counter=0: `out_valid`=1 and state returns to IDLE.
    - `in_ready` = (counter==0) && !flush, so a back-to-back accept is possible in the final cycle.
- **Flush:** in any state, the next state is IDLE, counter=0, and no `out_valid`/`alu_start` is produced for the aborted op. Flush wins over a simultaneous `in_valid`; that input is not accepted.
- **Reset:** same effect as flush, and additionally clears all registered outputs. Reset mid-EXEC discards the op with no `out_valid`.
- **Reset values:** `out_valid`=0, `alu_func`=0, `alu_start`=0, `busy`=0, `illegal`=0. `in_ready`=0 while `rst`=1.
- **Counter:** width $clog2(MC_CYCLES); no wrap, since it is reloaded only on accept.

## Timing
- **Single-cycle op** accepted at edge N: `out_valid`, `alu_func` and `illegal` are valid from edge N+1 for one cycle. Throughput is 1 op/cycle.
- **Multi-cycle op** accepted at edge N:
  - `busy`=1 from N+1 through N+MC_CYCLES.
  - `alu_start`=1 only in the cycle after N+1.
  - `out_valid`=1 in the cycle after N+MC_CYCLES.
  - `in_ready`=0 in cycles N+1..N+MC_CYCLES−1.
- `busy` falls in the cycle after the `out_valid` pulse, unless a new multi-cycle op was accepted in that final cycle, in which case `busy` stays 1 and `alu_start` pulses again.
- `out_valid` is never asserted without a prior accept. `alu_func` holds its last value when idle.

## Structure
- Package `alu_ctrl_pkg`:
  - `FUNC_*` constants (ADD=0, SUB=1, ..., MUL=8, MULH=9).
  - `ALUOP_*` constants (RTYPE=00, SUB=01, ADD=10).
  - State enum `{IDLE, EXEC}`.
- Sub-module `alu_ctrl_decode`: purely combinational decode of `{alu_op, opcode}` to `{func, multi, illegal}`.
- The top module contains the FSM, counter and output registers.

## Test plan
- After reset, alu_op=10/opcode=5 accepted → next cycle `out_valid`=1, `alu_func`=0, `illegal`=0. Then 00/0100 → `alu_func`=2; 00/1001 → 7.
- Back-to-back: 8 single-cycle ops on consecutive cycles → 8 consecutive `out_valid` pulses in order, with `in_ready` held at 1.
- MC_CYCLES=4, 00/1010 at edge 0 → `alu_start` high in cycle 1, `busy` high cycles 1–4, `out_valid` with `alu_func`=8 in cycle 4, `in_ready`=0 in cycles 1–3. A second MULH offered in cycle 4 is accepted, and `alu_start` re-pulses in cycle 5.
- Illegal encodings 11/xxxx and 00/0000 → `out_valid`=1 with `illegal`=1 and `alu_func`=0, single-cycle.
- Flush in cycle 2 of a MUL, with `in_valid` also high → no `out_valid`, `busy`=0 next cycle, and the concurrent input is not accepted.
- `rst` asserted mid-EXEC → all outputs 0 next cycle; a fresh op is accepted the cycle after `rst` falls.
